// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit common-anode scanner:
// FSM states, active-low hex segment patterns and the display record.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_DEAD = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index = nibble value; bit0 = segment a .. bit6 = segment g, 0 = lit.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  function automatic int on_cycles(input int bri, input int w);
    return ((bri + 1) * w) / 8;
  endfunction

endpackage

// File: rtl/hex_to_7seg_ca.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_7seg_ca
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/disp_scan_4_ca.sv
// Four-digit common-anode scanner: per-slot dead time, brightness PWM,
// frame-synchronous data update and end-of-frame pulse.
module disp_scan_4_ca
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic        clk50MHz,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  input  logic [2:0]  brightness,
  output logic [6:0]  Segments,
  output logic        dp,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int W_ON  = SLOT_CYCLES - DEAD_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_ton, w_on_last;
  logic [1:0]       r_idx, w_idx_nxt;
  disp_t            r_stage, r_disp, w_src;
  logic             r_pend;
  logic             w_last, w_first, w_fb;
  logic [3:0]       w_nib, w_sel_nxt;
  logic [6:0]       w_seg;

  assign w_last    = (r_cnt == CNT_LAST);
  assign w_first   = (r_cnt == '0);
  assign w_fb      = w_first && (r_idx == 2'd0);
  assign w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt = w_last ? r_idx + 2'd1 : r_idx;
  assign w_on_last = DEAD_LAST + r_ton;

  // At a frame boundary the pending record is what this frame shows.
  assign w_src = (w_fb && r_pend) ? r_stage : r_disp;
  assign w_nib = w_src.data[{r_idx, 2'b00} +: 4];

  hex_to_7seg_ca u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DEAD:  if (r_cnt == DEAD_LAST) w_state_nxt = S_ON;
      S_ON:    if (w_last) w_state_nxt = S_DEAD;
               else if (r_cnt == w_on_last) w_state_nxt = S_OFF;
      S_OFF:   if (w_last) w_state_nxt = S_DEAD;
      default: w_state_nxt = S_DEAD;
    endcase
  end

  // Anodes are registered from the next state so they line up with it.
  always_comb begin
    w_sel_nxt = 4'hF;
    if (w_state_nxt == S_ON && !w_src.blank[w_idx_nxt])
      w_sel_nxt[w_idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk50MHz) begin
    if (!rst_n) begin
      r_state    <= S_DEAD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ton      <= '0;
      r_stage    <= '0;
      r_disp     <= '0;
      r_pend     <= 1'b0;
      Segments   <= SEG_BLANK;
      dp         <= 1'b1;
      digit_sel  <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      digit_sel  <= w_sel_nxt;
      frame_done <= (w_idx_nxt == 2'd3) && (w_cnt_nxt == CNT_LAST);
      // Cathodes settle during dead time, before the anode turns on.
      if (w_first) begin
        r_ton    <= CNT_W'(on_cycles(int'(brightness), W_ON));
        Segments <= w_src.blank[r_idx] ? SEG_BLANK : w_seg;
        dp       <= w_src.blank[r_idx] | ~w_src.dp[r_idx];
      end
      if (load)
        r_stage <= '{data: data_in, dp: dp_in, blank: blank_in};
      if (w_fb && r_pend)
        r_disp <= r_stage;
      r_pend <= load | (r_pend & ~w_fb);
    end
  end

endmodule

// File: tb/tb_disp_scan_4_ca.sv
// Bench for disp_scan_4_ca: table-driven decode/brightness vectors, directed
// multi-cycle sequences, and randomized traffic against a frame-level model.
module tb_disp_scan_4_ca;

  localparam int SLOT  = 18;
  localparam int DEAD  = 2;
  localparam int W     = SLOT - DEAD;
  localparam int FRAME = 4 * SLOT;

  logic        clk50MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic [2:0]  brightness = '0;
  logic [6:0]  Segments;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_done;

  disp_scan_4_ca #(.SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
    .clk50MHz   (clk50MHz),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .brightness (brightness),
    .Segments   (Segments),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #10 clk50MHz = ~clk50MHz;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
    logic [2:0] bri;
    int         on_cyc;
  } vec_t;
  vec_t vt[16];

  int n_chk = 0, n_fail = 0;

  // values applied to the DUT in the next cycle
  logic        d_rst = 1'b0, d_load = 1'b0;
  logic [15:0] d_data = '0;
  logic [3:0]  d_dp = '0, d_bl = '0;
  logic [2:0]  d_bri = '0;

  // reference model: time since release, staged/shown records, slot snapshot
  int          m_t = 0, m_ton = 0;
  logic        m_valid = 1'b0, m_pend = 1'b0;
  logic [15:0] m_st_data = '0, m_ds_data = '0;
  logic [3:0]  m_st_dp = '0, m_st_bl = '0, m_ds_dp = '0, m_ds_bl = '0;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;

  int          s_t = 0;
  logic [6:0]  s_seg;
  logic        s_dp, s_fd;
  logic [3:0]  s_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, s_t, act, exp);
    end
  endtask

  task automatic model_step();
    int p, d;
    if (!d_rst) begin
      m_t = 0; m_ton = 0; m_pend = 1'b0; m_valid = 1'b1;
      m_st_data = '0; m_st_dp = '0; m_st_bl = '0;
      m_ds_data = '0; m_ds_dp = '0; m_ds_bl = '0;
      m_seg = 7'h7F; m_dp = 1'b1;
      return;
    end
    p = m_t % SLOT;
    d = (m_t / SLOT) % 4;
    if (p == 0) begin
      m_ton = ((int'(d_bri) + 1) * W) / 8;
      if (d == 0 && m_pend) begin
        m_ds_data = m_st_data; m_ds_dp = m_st_dp; m_ds_bl = m_st_bl;
      end
      if (m_ds_bl[d]) begin
        m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        m_seg = vt[m_ds_data[d*4 +: 4]].seg; m_dp = ~m_ds_dp[d];
      end
    end
    m_pend = d_load || (m_pend && !(p == 0 && d == 0));
    if (d_load) begin
      m_st_data = d_data; m_st_dp = d_dp; m_st_bl = d_bl;
    end
    m_t++;
  endtask

  // One clock: sample and check the current cycle, drive the next inputs.
  task automatic cycle();
    int p, d;
    logic [3:0] es;
    logic ef;
    @(negedge clk50MHz);
    s_t = m_t; s_seg = Segments; s_dp = dp; s_sel = digit_sel; s_fd = frame_done;
    if (m_valid) begin
      p = m_t % SLOT;
      d = (m_t / SLOT) % 4;
      es = 4'hF;
      if (p >= DEAD && p < DEAD + m_ton && !m_ds_bl[d]) es[d] = 1'b0;
      ef = (p == SLOT - 1) && (d == 3);
      n_chk++;
      if ({s_sel, s_seg, s_dp, s_fd} !== {es, m_seg, m_dp, ef}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model t=%0d: sel=%b seg=%h dp=%b fd=%b, expected sel=%b seg=%h dp=%b fd=%b",
                   m_t, s_sel, s_seg, s_dp, s_fd, es, m_seg, m_dp, ef);
      end
    end
    rst_n = d_rst; load = d_load; data_in = d_data; dp_in = d_dp;
    blank_in = d_bl; brightness = d_bri;
    model_step();
  endtask

  task automatic run_to(input int ph);
    int g;
    g = 0;
    while (m_t % FRAME != ph && g < 2 * FRAME) begin
      cycle(); g++;
    end
    if (m_t % FRAME != ph) chk("run_to_phase", m_t % FRAME, ph);
  endtask

  task automatic measure_slot(input int dig, output int on_cnt, output logic [6:0] seg3);
    logic [3:0] pat;
    pat = 4'hF; pat[dig] = 1'b0;
    on_cnt = 0; seg3 = 7'h7F;
    if (m_t % SLOT != 0) chk("slot_align", m_t % SLOT, 0);
    for (int k = 0; k < SLOT; k++) begin
      cycle();
      d_load = 1'b0;
      if (s_sel == pat) on_cnt++;
      if (k == 3) seg3 = s_seg;
    end
  endtask

  task automatic find_fd(output int t_at);
    t_at = -1;
    for (int k = 0; k < 3 * FRAME && t_at < 0; k++) begin
      cycle();
      if (s_fd) t_at = s_t;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int on_cnt, nf, nchg, fd1, fd2;
    logic [6:0] seg3, prev;
    logic [6:0] exp_n[4];

    vt[0]  = '{4'h0, 7'h40, 3'd0, 2};   vt[1]  = '{4'h1, 7'h79, 3'd1, 4};
    vt[2]  = '{4'h2, 7'h24, 3'd2, 6};   vt[3]  = '{4'h3, 7'h30, 3'd3, 8};
    vt[4]  = '{4'h4, 7'h19, 3'd4, 10};  vt[5]  = '{4'h5, 7'h12, 3'd5, 12};
    vt[6]  = '{4'h6, 7'h02, 3'd6, 14};  vt[7]  = '{4'h7, 7'h78, 3'd7, 16};
    vt[8]  = '{4'h8, 7'h00, 3'd0, 2};   vt[9]  = '{4'h9, 7'h10, 3'd1, 4};
    vt[10] = '{4'hA, 7'h08, 3'd2, 6};   vt[11] = '{4'hB, 7'h03, 3'd3, 8};
    vt[12] = '{4'hC, 7'h46, 3'd4, 10};  vt[13] = '{4'hD, 7'h21, 3'd5, 12};
    vt[14] = '{4'hE, 7'h06, 3'd6, 14};  vt[15] = '{4'hF, 7'h0E, 3'd7, 16};

    // reset, then the first post-release cycle shows reset values
    d_rst = 1'b0; cycle(); cycle();
    d_rst = 1'b1; cycle();
    chk("rst_seg", s_seg, 7'h7F); chk("rst_dp", s_dp, 1'b1);
    chk("rst_sel", s_sel, 4'hF);  chk("rst_fd", s_fd, 1'b0);

    // 1234 loaded at cycle 5: frame 0 shows zeros, frame 1 shows the data
    d_bri = 3'd7;
    for (int k = 0; k < 4; k++) cycle();
    chk("f0_d0_seg", s_seg, 7'h40);
    d_data = 16'h1234; d_load = 1'b1; cycle(); d_load = 1'b0;
    run_to(0);
    measure_slot(0, on_cnt, seg3);
    chk("f1_d0_seg", seg3, 7'h19); chk("f1_d0_on", on_cnt, 16);

    // table: decode of every nibble and on-time for every brightness
    for (int i = 0; i < 16; i++) begin
      d_data = {4{vt[i].nib}}; d_bri = vt[i].bri; d_load = 1'b1;
      cycle(); d_load = 1'b0;
      run_to(0);
      measure_slot(0, on_cnt, seg3);
      chk("tbl_seg", seg3, vt[i].seg); chk("tbl_on", on_cnt, vt[i].on_cyc);
    end

    // minimum brightness on every digit
    d_bri = 3'd0; run_to(0);
    for (int g = 0; g < 4; g++) begin
      measure_slot(g, on_cnt, seg3);
      chk("bri0_on", on_cnt, 2);
    end

    // dead time at each boundary; cathodes stable while an anode is on
    d_bri = 3'd7; run_to(0);
    nf = 0; nchg = 0; prev = 7'h7F;
    for (int k = 0; k < FRAME; k++) begin
      cycle();
      if (s_sel == 4'hF) nf++;
      if (k > 0 && s_sel != 4'hF && s_seg != prev) nchg++;
      prev = s_seg;
    end
    chk("dead_cycles", nf, 2 * 4); chk("seg_chg_on", nchg, 0);

    // blanked digit 2 with its dp requested stays fully dark
    d_data = 16'h1234; d_dp = 4'b0100; d_bl = 4'b0100; d_load = 1'b1;
    cycle(); d_load = 1'b0;
    run_to(0); run_to(2 * SLOT);
    nf = 0; nchg = 0; on_cnt = 0;
    for (int k = 0; k < SLOT; k++) begin
      cycle();
      if (s_sel == 4'hF) nf++;
      if (k > 0 && s_seg == 7'h7F) nchg++;
      if (k > 0 && s_dp == 1'b1) on_cnt++;
    end
    chk("blank_sel", nf, SLOT); chk("blank_seg", nchg, SLOT - 1);
    chk("blank_dp", on_cnt, SLOT - 1);

    // load on a boundary that is itself transferring a pending record
    d_dp = '0; d_bl = '0; d_data = 16'h1234; d_load = 1'b1; cycle(); d_load = 1'b0;
    run_to(0);
    d_data = 16'hFFFF; d_load = 1'b1;
    exp_n[0] = 7'h19; exp_n[1] = 7'h30; exp_n[2] = 7'h24; exp_n[3] = 7'h79;
    for (int g = 0; g < 4; g++) begin
      measure_slot(g, on_cnt, seg3);
      chk("bnd_old_seg", seg3, exp_n[g]);
    end
    for (int g = 0; g < 4; g++) begin
      measure_slot(g, on_cnt, seg3);
      chk("bnd_new_seg", seg3, 7'h0E);
    end

    // one-cycle reset in the middle of digit 2's on-time
    run_to(2 * SLOT + 5);
    d_rst = 1'b0; cycle();
    chk("pre_rst_sel", s_sel, 4'b1011);
    d_rst = 1'b1; cycle();
    chk("post_rst_seg", s_seg, 7'h7F); chk("post_rst_dp", s_dp, 1'b1);
    chk("post_rst_sel", s_sel, 4'hF);  chk("post_rst_fd", s_fd, 1'b0);
    find_fd(fd1);
    chk("fd_first", fd1, FRAME - 1);
    find_fd(fd2);
    chk("fd_period", fd2 - fd1, FRAME);

    // randomized traffic, including mid-slot brightness changes and resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) d_bri = 3'($urandom_range(0, 7));
      d_load = ($urandom_range(0, 19) == 0);
      if (d_load) begin
        d_data = 16'($urandom); d_dp = 4'($urandom); d_bl = 4'($urandom);
      end
      d_rst = ($urandom_range(0, 499) != 0);
      cycle();
    end
    d_rst = 1'b1; d_load = 1'b0;
    for (int k = 0; k < FRAME; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
